md_ex_unit: RTL and testbench
=============================

Name:
md_ex_unit

Overview:
- Iterative-latency multiply/divide unit for the EX stage of the pipelined MIPS core.
- Executes mult, multu, div and divu on two 32-bit operands and holds the results in internal HI/LO registers.
- Also executes mthi and mtlo.
- Signals Busy while an operation is in flight so the pipeline can stall later HI/LO users.

Parameters:
- MULT_CYCLES, 5: cycles Busy stays high for mult/multu.
- DIV_CYCLES, 10: cycles Busy stays high for div/divu.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- reset  input  1  synchronous, active-low reset.
- Start  input  1  one-cycle launch strobe for mult/multu/div/divu.
- D1  input  32  operand rs; multiplicand/dividend; source for mthi/mtlo.
- D2  input  32  operand rt; multiplier/divisor.
- MDControl  input  3  op select: 000 none, 001 mult, 010 multu, 011 div, 100 divu, 101 mthi, 110 mtlo, 111 none.
- Busy  output  1  high while an arithmetic op is in progress.
- HI  output  32  HI register (registered).
- LO  output  32  LO register (registered).

Behaviour:
- Reset: at a rising edge with reset==0, HI=0, LO=0, Busy=0, cycle counter=0 and any in-flight op is aborted. Reset overrides every other input.
- Launch condition: rising edge with Start=1, Busy=0, and MDControl in 001..100.
  - D1, D2 and the op are latched at that edge (t0).
  - Counter is loaded with MULT_CYCLES or DIV_CYCLES.
  - Busy=1 from t0.
- Counting: counter decrements on each subsequent edge.
  - At edge t0+N the result is written to HI/LO, the counter reaches 0 and Busy returns to 0.
  - Busy is therefore high for exactly N cycles; HI/LO hold their old values until edge t0+N.
- Ignored launches:
  - Start while Busy=1 is ignored; the operands in flight are unaffected.
  - Start with MDControl of 000, 101, 110 or 111 launches nothing.
- mthi/mtlo:
  - MDControl=101 with Busy=0: HI<=D1 at the edge, no Busy, Start not required.
  - MDControl=110 with Busy=0: LO<=D1 at the edge, no Busy, Start not required.
  - Either while Busy=1: ignored.
- mult: {HI,LO} = signed(D1) * signed(D2), full 64-bit two's-complement product.
- multu: {HI,LO} = unsigned 64-bit product.
- div:
  - LO = signed quotient, truncated toward zero.
  - HI = remainder, carrying the sign of the dividend.
  - 0x80000000 / 0xffffffff gives LO=0x80000000, HI=0.
- divu: LO = unsigned quotient, HI = unsigned remainder.
- Divide by zero (div or divu): Busy still runs DIV_CYCLES; HI and LO are left unchanged.
- Results may be computed combinationally from the latched operands; only the write timing is cycle-exact.
- Operand changes on D1/D2/MDControl after the launch edge do not affect the result.

Test Plan:
- reset=0 for 2 cycles, then reset=1 -> HI=0, LO=0, Busy=0.
- mult, D1=0xffffffff, D2=0xffffffff, Start=1 one cycle:
  - Busy=1 for 5 cycles, then HI=0x00000000, LO=0x00000001.
  - Repeat as multu -> HI=0xfffffffe, LO=0x00000001.
- mult, D1=1, D2=2 -> HI=0, LO=2. Start re-asserted with other operands during Busy -> ignored, result still HI=0, LO=2.
- Signed division, each with Busy for 10 cycles:
  - div 0x11110000/0x00000010 -> LO=0x01111000, HI=0.
  - div 0xfffffff9/0x00000002 -> LO=0xfffffffd, HI=0xffffffff.
  - div 0x0000000a/0xff2934b0 -> LO=0, HI=0x0000000a.
- div 0xffffff00/0xfffffffc -> LO=0x00000040, HI=0. Same operands as divu -> LO=0, HI=0xffffff00.
- Move-to and corner cases:
  - mthi D1=0x12345678 -> HI=0x12345678 next edge, Busy stays 0.
  - mtlo D1=0x19876543 -> LO=0x19876543.
  - divu by 0 -> HI/LO unchanged after Busy drops.
  - reset=0 mid-div -> Busy=0, HI=LO=0 at that edge.

Source files
------------

// File: rtl/md_ex_unit.sv
// Multiply/divide unit for the EX stage: holds HI/LO, runs mult/multu/div/divu
// with a fixed cycle latency and executes mthi/mtlo when idle.
module md_ex_unit #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Start,
  input  logic [31:0] D1,
  input  logic [31:0] D2,
  input  logic [2:0]  MDControl,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam logic [2:0] OP_MULT  = 3'b001;
  localparam logic [2:0] OP_MULTU = 3'b010;
  localparam logic [2:0] OP_DIV   = 3'b011;
  localparam logic [2:0] OP_DIVU  = 3'b100;
  localparam logic [2:0] OP_MTHI  = 3'b101;
  localparam logic [2:0] OP_MTLO  = 3'b110;

  localparam int unsigned CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CW      = $clog2(CNT_MAX + 1);

  logic [2:0]    op_q;
  logic [31:0]   a_q;
  logic [31:0]   b_q;
  logic [CW-1:0] cnt_q;
  logic          busy_q;

  logic          launch;
  logic          is_div;
  logic [63:0]   prod_s;
  logic [63:0]   prod_u;
  logic [31:0]   a_mag;
  logic [31:0]   b_mag;
  logic [31:0]   q_mag;
  logic [31:0]   r_mag;
  logic [31:0]   q_s;
  logic [31:0]   r_s;
  logic [31:0]   q_u;
  logic [31:0]   r_u;
  logic          div0;
  logic          wr_en;
  logic [31:0]   hi_res;
  logic [31:0]   lo_res;

  assign launch = Start && !busy_q &&
                  (MDControl == OP_MULT || MDControl == OP_MULTU ||
                   MDControl == OP_DIV  || MDControl == OP_DIVU);
  assign is_div = (MDControl == OP_DIV) || (MDControl == OP_DIVU);

  // Low 64 bits of the product of sign-extended operands is the exact signed product.
  assign prod_s = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
  assign prod_u = {32'd0, a_q} * {32'd0, b_q};

  // Signed divide via magnitudes; 0x80000000 as an unsigned magnitude is exact,
  // so INT_MIN / -1 wraps to INT_MIN with remainder 0.
  assign div0  = (b_q == '0);
  assign a_mag = a_q[31] ? (~a_q + 32'd1) : a_q;
  assign b_mag = b_q[31] ? (~b_q + 32'd1) : b_q;

  always_comb begin
    q_mag = '0;
    r_mag = '0;
    q_u   = '0;
    r_u   = '0;
    if (!div0) begin
      q_mag = a_mag / b_mag;
      r_mag = a_mag % b_mag;
      q_u   = a_q / b_q;
      r_u   = a_q % b_q;
    end
  end

  assign q_s = (a_q[31] ^ b_q[31]) ? (~q_mag + 32'd1) : q_mag;
  assign r_s = a_q[31] ? (~r_mag + 32'd1) : r_mag;

  always_comb begin
    hi_res = HI;
    lo_res = LO;
    wr_en  = 1'b0;
    unique case (op_q)
      OP_MULT: begin
        hi_res = prod_s[63:32];
        lo_res = prod_s[31:0];
        wr_en  = 1'b1;
      end
      OP_MULTU: begin
        hi_res = prod_u[63:32];
        lo_res = prod_u[31:0];
        wr_en  = 1'b1;
      end
      OP_DIV: begin
        hi_res = r_s;
        lo_res = q_s;
        wr_en  = !div0;
      end
      OP_DIVU: begin
        hi_res = r_u;
        lo_res = q_u;
        wr_en  = !div0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      op_q   <= '0;
      a_q    <= '0;
      b_q    <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      HI     <= '0;
      LO     <= '0;
    end else if (busy_q) begin
      // Result lands on the edge where the counter expires; nothing else is accepted while busy.
      if (cnt_q == CW'(1)) begin
        cnt_q  <= '0;
        busy_q <= 1'b0;
        if (wr_en) begin
          HI <= hi_res;
          LO <= lo_res;
        end
      end else begin
        cnt_q <= cnt_q - CW'(1);
      end
    end else if (launch) begin
      op_q   <= MDControl;
      a_q    <= D1;
      b_q    <= D2;
      cnt_q  <= is_div ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
      busy_q <= 1'b1;
    end else if (MDControl == OP_MTHI) begin
      HI <= D1;
    end else if (MDControl == OP_MTLO) begin
      LO <= D1;
    end
  end

  assign Busy = busy_q;

endmodule

// File: tb/tb_md_ex_unit.sv
// Directed-vector bench for md_ex_unit: latency, HI/LO results, ignored
// launches, move-to ops, divide by zero and reset abort.
module tb_md_ex_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        Start;
  logic [31:0] D1;
  logic [31:0] D2;
  logic [2:0]  MDControl;
  logic        Busy;
  logic [31:0] HI;
  logic [31:0] LO;

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  md_ex_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .Start(Start), .D1(D1), .D2(D2),
    .MDControl(MDControl), .Busy(Busy), .HI(HI), .LO(LO)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int unsigned n,
                        input logic [31:0] ehi, input logic [31:0] elo);
    logic [31:0] hi0, lo0;
    int unsigned cyc;
    logic held;
    hi0 = HI; lo0 = LO;
    Start = 1'b1; MDControl = op; D1 = a; D2 = b;
    tick();
    Start = 1'b0; MDControl = 3'b000; D1 = $urandom; D2 = $urandom;
    cyc = 0; held = 1'b1;
    while (Busy && cyc < 40) begin
      if (HI !== hi0 || LO !== lo0) held = 1'b0;
      tick();
      cyc++;
    end
    chk({tag, " busy_cycles"}, cyc, n);
    chk({tag, " hilo_held"}, {31'd0, held}, 32'd1);
    chk({tag, " HI"}, HI, ehi);
    chk({tag, " LO"}, LO, elo);
  endtask

  initial begin
    int unsigned cyc;
    reset = 1'b0; Start = 1'b0; D1 = '0; D2 = '0; MDControl = 3'b000;
    tick(); tick();
    reset = 1'b1;
    chk("rst HI", HI, 32'h0);
    chk("rst LO", LO, 32'h0);
    chk("rst Busy", {31'd0, Busy}, 32'd0);

    run_op("mult -1*-1",  3'b001, 32'hffffffff, 32'hffffffff, 5, 32'h00000000, 32'h00000001);
    run_op("multu max^2", 3'b010, 32'hffffffff, 32'hffffffff, 5, 32'hfffffffe, 32'h00000001);

    // mult 1*2 with a div launch and an mthi attempted while busy
    Start = 1'b1; MDControl = 3'b001; D1 = 32'd1; D2 = 32'd2;
    tick();
    Start = 1'b0; MDControl = 3'b000;
    tick();
    Start = 1'b1; MDControl = 3'b011; D1 = 32'h00001234; D2 = 32'h00000007;
    tick();
    Start = 1'b0; MDControl = 3'b101; D1 = 32'hdeadbeef;
    tick();
    MDControl = 3'b000;
    cyc = 3;
    while (Busy && cyc < 40) begin
      tick();
      cyc++;
    end
    chk("ign busy_cycles", cyc, 5);
    chk("ign HI", HI, 32'h0);
    chk("ign LO", LO, 32'h2);
    tick();
    chk("ign no relaunch", {31'd0, Busy}, 32'd0);

    run_op("div pos",     3'b011, 32'h11110000, 32'h00000010, 10, 32'h00000000, 32'h01111000);
    run_op("div -7/2",    3'b011, 32'hfffffff9, 32'h00000002, 10, 32'hffffffff, 32'hfffffffd);
    run_op("div 10/neg",  3'b011, 32'h0000000a, 32'hff2934b0, 10, 32'h0000000a, 32'h00000000);
    run_op("div -256/-4", 3'b011, 32'hffffff00, 32'hfffffffc, 10, 32'h00000000, 32'h00000040);
    run_op("divu",        3'b100, 32'hffffff00, 32'hfffffffc, 10, 32'hffffff00, 32'h00000000);
    run_op("div min/-1",  3'b011, 32'h80000000, 32'hffffffff, 10, 32'h00000000, 32'h80000000);

    MDControl = 3'b101; D1 = 32'h12345678;
    tick();
    chk("mthi HI", HI, 32'h12345678);
    chk("mthi Busy", {31'd0, Busy}, 32'd0);
    MDControl = 3'b110; D1 = 32'h19876543;
    tick();
    chk("mtlo LO", LO, 32'h19876543);
    chk("mtlo HI kept", HI, 32'h12345678);
    MDControl = 3'b000;

    Start = 1'b1; MDControl = 3'b111; D1 = 32'h5; D2 = 32'h6;
    tick();
    Start = 1'b0; MDControl = 3'b000;
    chk("op111 no Busy", {31'd0, Busy}, 32'd0);

    run_op("divu by0", 3'b100, 32'h00000005, 32'h00000000, 10, 32'h12345678, 32'h19876543);
    run_op("div by0",  3'b011, 32'h80000000, 32'h00000000, 10, 32'h12345678, 32'h19876543);

    Start = 1'b1; MDControl = 3'b011; D1 = 32'h00000100; D2 = 32'h00000003;
    tick();
    Start = 1'b0; MDControl = 3'b000;
    tick(); tick();
    chk("middiv Busy", {31'd0, Busy}, 32'd1);
    reset = 1'b0;
    tick();
    chk("middiv rst Busy", {31'd0, Busy}, 32'd0);
    chk("middiv rst HI", HI, 32'h0);
    chk("middiv rst LO", LO, 32'h0);
    reset = 1'b1;
    for (int i = 0; i < 12; i++) tick();
    chk("aborted Busy", {31'd0, Busy}, 32'd0);
    chk("aborted LO", LO, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
